// File: rtl/counter_mod_n_if.sv
// counter_mod_n_if
//   Groups the control and status signals of counter_mod_n.
//   master: drives en, up, load, load_val; observes count, reached, wraps.
//   slave : the counter itself.
// Signals
//   en        count enable
//   up        direction, 1 = up, 0 = down
//   load      synchronous load strobe
//   load_val  value loaded when load=1 (WIDTH bits)
//   count     current count (WIDTH bits)
//   reached   terminal-count indication
//   wraps     rollover tally (WRAP_W bits)
interface counter_mod_n_if #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned WRAP_W = 8
);
   logic              en;
   logic              up;
   logic              load;
   logic [WIDTH-1:0]  load_val;
   logic [WIDTH-1:0]  count;
   logic              reached;
   logic [WRAP_W-1:0] wraps;

   modport master (
      output en, up, load, load_val,
      input  count, reached, wraps
   );

   modport slave (
      input  en, up, load, load_val,
      output count, reached, wraps
   );
endinterface

// File: rtl/counter_mod_n.sv
// counter_mod_n
//   Modulo-MODULUS up/down counter with enable, synchronous load (clamped to
//   MODULUS-1), terminal-count indication and a rollover tally.
//   Optional macro COUNTER_SATURATE_EN selects saturate mode: counting stops at
//   the terminal value, wraps stays 0 and reached becomes a registered level.
// Ports
//   tick        clock, rising edge
//   runCounter  asynchronous active-low reset
//   bus         counter_mod_n_if.slave (en, up, load, load_val in;
//               count, reached, wraps out, all registered)
// Parameters
//   WIDTH    count register width
//   MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   WRAP_W   rollover counter width
module counter_mod_n #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned MODULUS = 10000,
   parameter int unsigned WRAP_W  = 8
) (
   input  logic            tick,
   input  logic            runCounter,
   counter_mod_n_if.slave  bus
);

   // MODULUS-1 always fits in WIDTH bits, even for MODULUS = 2**WIDTH.
   localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH-1:0] ZERO = '0;

   logic [WIDTH-1:0]  count_q, count_d;
   logic              reached_q, reached_d;
   logic [WRAP_W-1:0] wraps_q, wraps_d;
   logic [WIDTH-1:0]  load_clamped;

   assign load_clamped = (bus.load_val > TERM) ? TERM : bus.load_val;

`ifdef COUNTER_SATURATE_EN
   always_comb begin
      count_d = count_q;
      wraps_d = '0;
      if (bus.load) begin
         count_d = load_clamped;
      end else if (bus.en) begin
         if (bus.up) begin
            count_d = (count_q == TERM) ? count_q : count_q + WIDTH'(1);
         end else begin
            count_d = (count_q == ZERO) ? count_q : count_q - WIDTH'(1);
         end
      end
      // Level against the terminal value of the direction currently selected.
      reached_d = (count_d == (bus.up ? TERM : ZERO));
   end
`else
   always_comb begin
      count_d   = count_q;
      reached_d = 1'b0;
      wraps_d   = wraps_q;
      if (bus.load) begin
         count_d = load_clamped;
      end else if (bus.en) begin
         if (bus.up) begin
            // Compare before incrementing so MODULUS = 2**WIDTH cannot overflow.
            if (count_q == TERM) begin
               count_d   = ZERO;
               reached_d = 1'b1;
               wraps_d   = wraps_q + WRAP_W'(1);
            end else begin
               count_d = count_q + WIDTH'(1);
            end
         end else begin
            if (count_q == ZERO) begin
               count_d   = TERM;
               reached_d = 1'b1;
               wraps_d   = wraps_q + WRAP_W'(1);
            end else begin
               count_d = count_q - WIDTH'(1);
            end
         end
      end
   end
`endif

   always_ff @(posedge tick or negedge runCounter) begin
      if (!runCounter) begin
         count_q   <= '0;
         reached_q <= 1'b0;
         wraps_q   <= '0;
      end else begin
         count_q   <= count_d;
         reached_q <= reached_d;
         wraps_q   <= wraps_d;
      end
   end

   assign bus.count   = count_q;
   assign bus.reached = reached_q;
   assign bus.wraps   = wraps_q;

endmodule

// File: tb/tb_counter_mod_n.sv
// tb_counter_mod_n
//   Three counters share one stimulus stream: d0 (WIDTH 16, MODULUS 10000),
//   d1 (WIDTH 2, MODULUS 4 = 2**WIDTH) and d2 (WIDTH 4, MODULUS 2, WRAP_W 2).
//   A reference model tracks all three with plain integer arithmetic.
module tb_counter_mod_n;

   logic        tick = 1'b0;
   logic        runCounter;
   logic        en, up, load;
   logic [15:0] lv;

   always #5 tick = ~tick;

   counter_mod_n_if #(.WIDTH(16), .WRAP_W(8)) i0 ();
   counter_mod_n_if #(.WIDTH(2),  .WRAP_W(2)) i1 ();
   counter_mod_n_if #(.WIDTH(4),  .WRAP_W(2)) i2 ();

   assign i0.en = en;  assign i0.up = up;  assign i0.load = load;  assign i0.load_val = lv;
   assign i1.en = en;  assign i1.up = up;  assign i1.load = load;  assign i1.load_val = lv[1:0];
   assign i2.en = en;  assign i2.up = up;  assign i2.load = load;  assign i2.load_val = lv[3:0];

   counter_mod_n #(.WIDTH(16), .MODULUS(10000), .WRAP_W(8)) d0 (
      .tick(tick), .runCounter(runCounter), .bus(i0));
   counter_mod_n #(.WIDTH(2), .MODULUS(4), .WRAP_W(2)) d1 (
      .tick(tick), .runCounter(runCounter), .bus(i1));
   counter_mod_n #(.WIDTH(4), .MODULUS(2), .WRAP_W(2)) d2 (
      .tick(tick), .runCounter(runCounter), .bus(i2));

   int n_pass  = 0;
   int n_total = 0;

   int mods[3];
   int wbits[3];
   int lvbits[3];
   int mcnt[3];
   int mrch[3];
   int mwr[3];

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         mcnt[i] = 0;
         mrch[i] = 0;
         mwr[i]  = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 3; i++) begin
         int t;
         int v;
         t = mods[i] - 1;
         v = int'(lv) & ((1 << lvbits[i]) - 1);
`ifdef COUNTER_SATURATE_EN
         if (load) mcnt[i] = (v > t) ? t : v;
         else if (en && up) mcnt[i] = (mcnt[i] + 1 > t) ? t : mcnt[i] + 1;
         else if (en && !up) mcnt[i] = (mcnt[i] > 0) ? mcnt[i] - 1 : 0;
         mrch[i] = (mcnt[i] == (up ? t : 0)) ? 1 : 0;
         mwr[i]  = 0;
`else
         mrch[i] = 0;
         if (load) begin
            mcnt[i] = (v > t) ? t : v;
         end else if (en) begin
            if ((up && mcnt[i] == t) || (!up && mcnt[i] == 0)) begin
               mrch[i] = 1;
               mwr[i]  = (mwr[i] + 1) % (1 << wbits[i]);
            end
            mcnt[i] = up ? (mcnt[i] + 1) % mods[i] : (mcnt[i] + mods[i] - 1) % mods[i];
         end
`endif
      end
   endtask

   task automatic compare_all();
      check("d0 count",   int'(i0.count),   mcnt[0]);
      check("d0 reached", int'(i0.reached), mrch[0]);
      check("d0 wraps",   int'(i0.wraps),   mwr[0]);
      check("d1 count",   int'(i1.count),   mcnt[1]);
      check("d1 reached", int'(i1.reached), mrch[1]);
      check("d1 wraps",   int'(i1.wraps),   mwr[1]);
      check("d2 count",   int'(i2.count),   mcnt[2]);
      check("d2 reached", int'(i2.reached), mrch[2]);
      check("d2 wraps",   int'(i2.wraps),   mwr[2]);
   endtask

   // Inputs are set before the call (away from the edge); outputs sampled on negedge.
   task automatic cycle();
      @(posedge tick);
      model_step();
      @(negedge tick);
      compare_all();
   endtask

   // Reset pulse between edges; outputs must clear without any tick.
   task automatic do_reset();
      #1 runCounter = 1'b0;
      #1;
      check("async rst d0 count",   int'(i0.count),   0);
      check("async rst d0 reached", int'(i0.reached), 0);
      check("async rst d0 wraps",   int'(i0.wraps),   0);
      check("async rst d1 count",   int'(i1.count),   0);
      check("async rst d2 wraps",   int'(i2.wraps),   0);
      #1 runCounter = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic        en;
      logic        up;
      logic        load;
      logic [15:0] lv;
      int          cnt;
      int          rch;
      int          wr;
   } vec_t;

   vec_t vecs[12];

   initial begin
      mods   = '{10000, 4, 2};
      wbits  = '{8, 2, 2};
      lvbits = '{16, 2, 4};
      model_reset();
      runCounter = 1'b0;
      en = 1'b0; up = 1'b1; load = 1'b0; lv = '0;
      repeat (2) @(negedge tick);
      compare_all();
      check("reset d0 count", int'(i0.count), 0);
      runCounter = 1'b1;

`ifndef COUNTER_SATURATE_EN
      // Full up-count to the first wrap of d0.
      do_reset();
      en = 1'b1; up = 1'b1;
      repeat (9999) cycle();
      check("t1 count at 9999",  int'(i0.count),   9999);
      check("t1 no early reach", int'(i0.reached), 0);
      cycle();
      check("t1 wrap count",   int'(i0.count),   0);
      check("t1 wrap reached", int'(i0.reached), 1);
      check("t1 wrap wraps",   int'(i0.wraps),   1);
      cycle();
      check("t1 pulse ends", int'(i0.reached), 0);
      check("t1 count 1",    int'(i0.count),   1);

      // Table of single-cycle vectors for d0.
      vecs[0]  = '{1'b0, 1'b1, 1'b1, 16'd0,    0,    0, 0};
      vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'd0,    9999, 1, 1};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'd0,    9998, 0, 1};
      vecs[3]  = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 9999, 0, 1};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'd0,    0,    1, 2};
      vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'd0,    0,    0, 2};
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'd0,    1,    0, 2};
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'd9998, 9998, 0, 2};
      vecs[8]  = '{1'b1, 1'b1, 1'b0, 16'd0,    9999, 0, 2};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'd0,    9998, 0, 2};
      vecs[10] = '{1'b1, 1'b1, 1'b0, 16'd0,    9999, 0, 2};
      vecs[11] = '{1'b1, 1'b1, 1'b0, 16'd0,    0,    1, 3};
      do_reset();
      for (int k = 0; k < 12; k++) begin
         en = vecs[k].en; up = vecs[k].up; load = vecs[k].load; lv = vecs[k].lv;
         cycle();
         check($sformatf("vec%0d count", k),   int'(i0.count),   vecs[k].cnt);
         check($sformatf("vec%0d reached", k), int'(i0.reached), vecs[k].rch);
         check($sformatf("vec%0d wraps", k),   int'(i0.wraps),   vecs[k].wr);
      end

      // Reset mid-count at count 5000, wraps 3, then restart 0,1,2.
      en = 1'b0; load = 1'b1; lv = 16'd5000;
      cycle();
      check("t4 pre count", int'(i0.count), 5000);
      check("t4 pre wraps", int'(i0.wraps), 3);
      load = 1'b0;
      do_reset();
      en = 1'b1; up = 1'b1;
      cycle();
      check("t4 restart 1", int'(i0.count), 1);
      cycle();
      check("t4 restart 2", int'(i0.count), 2);

      // d2 (MODULUS 2): reached on every second edge, wraps 1,2,3,0.
      do_reset();
      en = 1'b1; up = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         cycle();
         check($sformatf("t5 reached e%0d", k), int'(i2.reached), (k % 2 == 0) ? 1 : 0);
         check($sformatf("t5 wraps e%0d", k),   int'(i2.wraps),   (k / 2) % 4);
      end
      en = 1'b0;
      cycle();
      check("t5 hold count",   int'(i2.count),   0);
      check("t5 hold reached", int'(i2.reached), 0);
`else
      // Saturation on d1 (MODULUS 4).
      do_reset();
      en = 1'b1; up = 1'b1;
      repeat (6) cycle();
      check("sat up count",   int'(i1.count),   3);
      check("sat up reached", int'(i1.reached), 1);
      up = 1'b0;
      cycle();
      check("sat dir reached", int'(i1.reached), 0);
      repeat (3) cycle();
      check("sat down count",   int'(i1.count),   0);
      check("sat down reached", int'(i1.reached), 1);
      check("sat wraps",        int'(i1.wraps),   0);
`endif

      // Randomized run against the model.
      for (int k = 0; k < 3000; k++) begin
         en   = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) up = ~up;
         load = ($urandom_range(0, 15) == 0);
         lv   = 16'($urandom);
         if ($urandom_range(0, 499) == 0) do_reset();
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
